// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bundle: per-master request/lock, muxed transfer control in,
// grant and ownership indices out. The arbiter uses the slave modport.
interface ahb_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [1:0]             HMASTER;
    logic [1:0]             HMASTER_D;
    logic                   HMASTLOCK;

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Burst- and lock-aware AHB arbiter with registered one-hot grant and owner indices.
// Define ARB_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (master 0 highest).
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic         HCLK,
    input  logic         HRESET,
    ahb_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] TR_BUSY    = 2'd1;
    localparam logic [1:0] TR_NONSEQ  = 2'd2;
    localparam logic [1:0] TR_SEQ     = 2'd3;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_master;
    logic [IDX_W-1:0]       r_master_d;
    logic                   r_mastlock;
    logic [CNT_W-1:0]       r_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]       r_ptr;
`endif

    logic                   w_fixed;
    logic [CNT_W-1:0]       w_len_m1;
    logic                   w_nonseq_fixed;
    logic                   w_owner_lock;
    logic                   w_next_lock;
    logic                   w_open;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_found;
    logic [IDX_W-1:0]       w_win_idx;
    logic [NUM_MASTERS-1:0] w_win_grant;

    // Fixed-length burst decode: beats remaining after the NONSEQ
    always_comb begin
        w_fixed  = 1'b1;
        w_len_m1 = '0;
        case (bus.HBURST)
            3'd2, 3'd3: w_len_m1 = CNT_W'(3);
            3'd4, 3'd5: w_len_m1 = CNT_W'(7);
            3'd6, 3'd7: w_len_m1 = CNT_W'(15);
            default:    w_fixed  = 1'b0;
        endcase
    end

    assign w_nonseq_fixed = (bus.HTRANS == TR_NONSEQ) && w_fixed;

    // Lock of the address-phase owner and of the master about to take ownership
    always_comb begin
        w_owner_lock = 1'b0;
        w_next_lock  = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (r_master == IDX_W'(i))    w_owner_lock = bus.HLOCK[i];
            if (r_grant_idx == IDX_W'(i)) w_next_lock  = bus.HLOCK[i];
        end
    end

    assign w_open = (((r_cnt == '0) && !w_nonseq_fixed) ||
                     ((r_cnt == CNT_W'(1)) && (bus.HTRANS == TR_SEQ))) && !w_owner_lock;

    always_comb begin
        w_cnt_nxt = '0;
        if (w_nonseq_fixed)
            w_cnt_nxt = w_len_m1;
        else if ((bus.HTRANS == TR_SEQ) && (r_cnt != '0))
            w_cnt_nxt = r_cnt - CNT_W'(1);
        else if (bus.HTRANS == TR_BUSY)
            w_cnt_nxt = r_cnt;
    end

    // Winner selection; default master when nobody requests
    always_comb begin
        w_win_idx = DEF_IDX;
        w_found   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                if (!w_found && bus.HBUSREQ[i] &&
                    (((32'(r_ptr) + k) % NUM_MASTERS) == i)) begin
                    w_found   = 1'b1;
                    w_win_idx = IDX_W'(i);
                end
            end
        end
`else
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && bus.HBUSREQ[i]) begin
                w_found   = 1'b1;
                w_win_idx = IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        w_win_grant = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_win_idx == IDX_W'(i)) w_win_grant[i] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_grant     <= DEF_GRANT;
            r_grant_idx <= DEF_IDX;
            r_master    <= DEF_IDX;
            r_master_d  <= DEF_IDX;
            r_mastlock  <= 1'b0;
            r_cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr       <= DEF_IDX;
`endif
        end else if (bus.HREADY) begin
            r_cnt      <= w_cnt_nxt;
            r_master   <= r_grant_idx;
            r_master_d <= r_master;
            r_mastlock <= w_next_lock;
            if (w_open) begin
                r_grant     <= w_win_grant;
                r_grant_idx <= w_win_idx;
`ifdef ARB_ROUND_ROBIN_EN
                r_ptr       <= w_win_idx;
`endif
            end
        end else if (bus.HRESP == RESP_ERROR) begin
            // ERROR abandons the burst so the next ready edge can re-arbitrate
            r_cnt <= '0;
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = r_master;
    assign bus.HMASTER_D = r_master_d;
    assign bus.HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus biased random traffic checked
// against a rule-level reference model of grant, ownership and burst tracking.
module tb_ahb_arbiter;
    localparam int unsigned N   = 2;
    localparam int unsigned DEF = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int m_grant, m_master, m_master_d, m_ptr, m_cnt;
    bit m_lock;
    int blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    function automatic void model_reset();
        m_grant = DEF; m_master = DEF; m_master_d = DEF;
        m_ptr = DEF; m_cnt = 0; m_lock = 1'b0;
    endfunction

    function automatic int pick(input logic [N-1:0] breq);
        if (breq == '0) return DEF;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++)
            if (breq[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (breq[i]) return i;
`endif
        return DEF;
    endfunction

    function automatic void model_edge(input logic [N-1:0] breq, input logic [N-1:0] lock,
                                       input logic [1:0] trans, input logic [2:0] burst,
                                       input logic ready, input logic [1:0] resp);
        bit fixed, open;
        int ncnt, ngrant;
        if (ready) begin
            fixed = blen[burst] > 1;
            open  = (m_cnt == 0 && !(trans == 2 && fixed)) || (m_cnt == 1 && trans == 3);
            if (lock[m_master]) open = 1'b0;
            if (trans == 2 && fixed)      ncnt = blen[burst] - 1;
            else if (trans == 3 && m_cnt > 0) ncnt = m_cnt - 1;
            else if (trans == 1)          ncnt = m_cnt;
            else                          ncnt = 0;
            ngrant = open ? pick(breq) : m_grant;
            if (ngrant != m_grant) m_ptr = ngrant;
            m_master_d = m_master;
            m_lock     = lock[m_grant];
            m_master   = m_grant;
            m_grant    = ngrant;
            m_cnt      = ncnt;
        end else if (resp == 2'd1) begin
            m_cnt = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grant"},    32'(bus.HGRANT),    32'(1) << m_grant);
        check({tag, ".master"},   32'(bus.HMASTER),   32'(m_master));
        check({tag, ".master_d"}, 32'(bus.HMASTER_D), 32'(m_master_d));
        check({tag, ".mastlock"}, 32'(bus.HMASTLOCK), 32'(m_lock));
        check({tag, ".onehot"},   32'($onehot(bus.HGRANT)), 32'(1));
    endtask

    task automatic step(input logic [N-1:0] breq, input logic [N-1:0] lock,
                        input logic [1:0] trans, input logic [2:0] burst,
                        input logic ready, input logic [1:0] resp, input string tag);
        bus.HBUSREQ = breq;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = ready;
        bus.HRESP   = resp;
        @(posedge clk);
        model_edge(breq, lock, trans, burst, ready, resp);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".grant"},    32'(bus.HGRANT),    32'h1);
        check({tag, ".master"},   32'(bus.HMASTER),   32'h0);
        check({tag, ".master_d"}, 32'(bus.HMASTER_D), 32'h0);
        check({tag, ".mastlock"}, 32'(bus.HMASTLOCK), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.HBUSREQ = '0; bus.HLOCK = '0; bus.HTRANS = 2'd0;
        bus.HBURST = 3'd0; bus.HREADY = 1'b1; bus.HRESP = 2'd0;
        model_reset();
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;

        // Idle after release: default master keeps grant
        step(2'b00, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "idle0");
        step(2'b00, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "idle1");
        check("idle_grant", 32'(bus.HGRANT), 32'h1);

        // Master 1 alone: grant, then ownership, then data-phase ownership
        step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "req1_e1");
        check("req1_grant_e1", 32'(bus.HGRANT), 32'h2);
        step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "req1_e2");
        check("req1_master_e2", 32'(bus.HMASTER), 32'h1);
        step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "req1_e3");
        check("req1_master_d_e3", 32'(bus.HMASTER_D), 32'h1);

        // INCR4 by master 1 while master 0 waits
        step(2'b11, 2'b00, 2'd2, 3'd3, 1'b1, 2'd0, "incr4_ns");
        check("incr4_hold_ns", 32'(bus.HGRANT), 32'h2);
        step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 2'd0, "incr4_s1");
        check("incr4_hold_s1", 32'(bus.HGRANT), 32'h2);
        step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 2'd0, "incr4_s2");
        check("incr4_hold_s2", 32'(bus.HGRANT), 32'h2);
        step(2'b11, 2'b00, 2'd3, 3'd3, 1'b1, 2'd0, "incr4_s3");
        check("incr4_handover", 32'(bus.HGRANT), 32'h1);
        step(2'b01, 2'b00, 2'd2, 3'd0, 1'b1, 2'd0, "incr4_next");
        check("incr4_new_owner", 32'(bus.HMASTER), 32'h0);

        // Master 0 locked while both request
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b01, 2'd2, 3'd0, 1'b1, 2'd0, "lock");
            check("lock_grant", 32'(bus.HGRANT), 32'h1);
            check("lock_mastlock", 32'(bus.HMASTLOCK), 32'h1);
        end
        step(2'b10, 2'b00, 2'd2, 3'd0, 1'b1, 2'd0, "unlock");
        check("unlock_grant", 32'(bus.HGRANT), 32'h2);

        // Both masters issuing SINGLE continuously
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, 2'd2, 3'd0, 1'b1, 2'd0, "single");
`ifdef ARB_ROUND_ROBIN_EN
            check("single_rr", 32'(bus.HGRANT), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
            check("single_fixed", 32'(bus.HGRANT), 32'h1);
`endif
        end

        // INCR8 by master 1 ended by ERROR on beat 3
        step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "err_pre0");
        step(2'b10, 2'b00, 2'd0, 3'd0, 1'b1, 2'd0, "err_pre1");
        step(2'b11, 2'b00, 2'd2, 3'd5, 1'b1, 2'd0, "err_ns");
        step(2'b11, 2'b00, 2'd3, 3'd5, 1'b1, 2'd0, "err_s1");
        step(2'b11, 2'b00, 2'd3, 3'd5, 1'b1, 2'd0, "err_s2");
        check("err_hold_burst", 32'(bus.HGRANT), 32'h2);
        step(2'b11, 2'b00, 2'd3, 3'd5, 1'b0, 2'd1, "err_c1");
        check("err_hold_wait", 32'(bus.HGRANT), 32'h2);
        step(2'b11, 2'b00, 2'd0, 3'd5, 1'b1, 2'd1, "err_c2");
        check("err_regrant", 32'(bus.HGRANT), 32'h1);

        // Reset in the middle of an INCR16
        step(2'b11, 2'b00, 2'd2, 3'd7, 1'b1, 2'd0, "rst_ns");
        step(2'b11, 2'b00, 2'd3, 3'd7, 1'b1, 2'd0, "rst_s1");
        #3 rst = 1'b1;
        #1 check_reset_outputs("reset_mid");
        model_reset();
        #1 rst = 1'b0;

        // Biased random traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [N-1:0] br, lk;
            logic [1:0]   tr, rs;
            logic [2:0]   bu;
            logic         rd;
            br = N'($urandom);
            lk = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            bu = 3'($urandom);
            if (m_cnt > 0 && $urandom_range(0, 9) < 8) tr = ($urandom_range(0, 7) == 0) ? 2'd1 : 2'd3;
            else tr = 2'($urandom);
            rd = ($urandom_range(0, 4) != 0);
            rs = (!rd && $urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            step(br, lk, tr, bu, rd, rs, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
